dpa_pipe: RTL and testbench
===========================

# dpa_pipe

Pipelined, parametrised carry-select adder/subtractor with arithmetic flags and valid/ready flow control. It is the successor to the combinational datapath adder:
- width and pipeline depth are generic;
- subtract and signed absolute-difference are explicit operations;
- all four flags are defined for every opcode;
- backpressure stalls the whole pipe.

It sits between the operand-fetch stage and the ALU result mux.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a multiple of `STAGES`.
- `STAGES`, 4, number of carry segments, one register stage per segment; `SEG = WIDTH/STAGES`.
- `OP_LEN`, 5, opcode width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  pipe can accept this cycle.
- `a`  in  `WIDTH`  operand A.
- `b`  in  `WIDTH`  operand B.
- `cin`  in  1  carry-in (`ADD` only).
- `alu_op`  in  `OP_LEN`  operation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  `WIDTH`  sum / difference / magnitude.
- `cout`  out  1  carry flag.
- `negative_flag`, `overflow_flag`, `zero_flag`  out  1 each  status flags.
- `op_err`  out  1  opcode was not supported.

## Operation
Opcodes:
- `OP_ADD` = 5'b00010: `a + b + cin`.
- `OP_SUB` = 5'b00011: `a + ~b + 1`; `cin` is ignored.
- `OP_ABSDIFF` = 5'b00001: signed `|a − b|`.
- Any other code: result 0, flags 0, `op_err` = 1. The token still flows through the pipe.

Segment stage `k` (0..`STAGES`−1):
- Computes bits `[k*SEG +: SEG]` as carry-select: p = a^b, g = a&b; sum0 = p, sum1 = ~p selected per bit by the ripple carry.
- Segment carry-in is the registered carry-out of stage `k−1`. Stage 0 carry-in is `cin` for `ADD`, 1 for `SUB`/`ABSDIFF`.
- Unconsumed operand bits and the opcode travel alongside the segment results.
- Stage `STAGES−1` also registers `c[WIDTH]` and `c[WIDTH−1]`.

Final stage (flags/negate):
- d = raw sum, v = `c[WIDTH] ^ c[WIDTH−1]`, s = `d[WIDTH−1] ^ v` (true sign of a−b).
- `ADD`/`SUB`: `result = d`, `cout = c[WIDTH]` (for `SUB`, 1 means no borrow), `negative_flag = d[WIDTH−1]`, `overflow_flag = v`.
- `ABSDIFF`: `result = s ? (~d + 1) : d`, interpreted as unsigned and always exact (max 2^`WIDTH`−1). `cout = s` (1 means a < b signed). `negative_flag` = 0, `overflow_flag` = 0.
- `zero_flag = (result == 0)` for every opcode. Arithmetic wraps modulo 2^`WIDTH`.

Flow control:
- Global enable: `en = ~out_valid | out_ready`; `in_ready = en`.
- Transfer on the input side when `in_valid & in_ready`; on the output side when `out_valid & out_ready`.
- When `en` = 0, every stage holds, including bubbles. When `en` = 1, every stage advances and bubbles propagate with valid = 0.
- The per-stage valid bit is the only control state; there is no FSM beyond this shift of valid tokens.

## Timing
- Latency is `STAGES + 1` cycles from input transfer to `out_valid`, with no stall.
- Throughput is 1 op/cycle while `out_ready` stays high.
- Reset (synchronous, any cycle, including mid-stall):
  - all stage valids clear;
  - `out_valid` = 0, `result` = 0, all flags 0, `op_err` = 0;
  - `in_ready` = 1 in the cycle after reset deasserts;
  - in-flight ops are discarded.
- `in_ready` depends combinationally on `out_ready`. This is the only comb path through the block.
- With `out_valid` = 1 and `out_ready` = 0, the outputs stay stable until accepted.
- Simultaneous output accept and input accept in one cycle is legal and required for full throughput.

## Structure
- Package `dpa_pkg`:
  - `OP_ADD`, `OP_SUB`, `OP_ABSDIFF` localparams;
  - `OP_LEN`;
  - flag bundle typedef {`cout`, `negative`, `overflow`, `zero`, `op_err`}.
- Sub-module `dpa_seg`: combinational `SEG`-bit carry-select slice with inputs a, b, ci and outputs sum, co, c_msb_in. It is instantiated `STAGES` times from a generate loop.
- Top level holds the stage registers, the enable logic and the final flag/negate stage.
- Elaboration check: `WIDTH % STAGES == 0`, else `$fatal`.

## Test plan
- `ADD`, `WIDTH` = 32, a = 0x7FFFFFFF, b = 1, cin = 0 -> result 0x80000000, overflow 1, negative 1, cout 0, zero 0, after 5 cycles.
- `SUB`, a = 5, b = 5 -> result 0, zero 1, cout 1; `SUB` a = 0, b = 1 -> 0xFFFFFFFF, negative 1, cout 0.
- `ABSDIFF`, a = 0x80000000, b = 0x7FFFFFFF -> result 0xFFFFFFFF, cout 1 (a < b); swapped operands -> same result, cout 0.
- Back-to-back stream of 16 random ops with `out_ready` toggling pseudo-randomly -> results match the reference model in order, none dropped or duplicated, and outputs hold while stalled.
- `alu_op` = 5'b11111 -> result 0, `op_err` 1, token emitted with normal latency.
- Assert `rst` with 3 ops in flight and `out_ready` = 0 -> next cycle all outputs 0, `out_valid` 0; a fresh op then completes with latency `STAGES + 1`.

Source files
------------

// File: rtl/dpa_pkg.sv
// Shared definitions for the dpa_pipe pipelined adder/subtractor.
// Contents: opcode width and opcode encodings, and the registered flag bundle.
package dpa_pkg;

  localparam int OP_LEN = 5;

  localparam logic [OP_LEN-1:0] OP_ABSDIFF = 5'b00001;
  localparam logic [OP_LEN-1:0] OP_ADD     = 5'b00010;
  localparam logic [OP_LEN-1:0] OP_SUB     = 5'b00011;

  // Status flags that travel with every result token.
  typedef struct packed {
    logic cout;
    logic negative;
    logic overflow;
    logic zero;
    logic op_err;
  } dpa_flags_t;

endpackage

// File: rtl/dpa_seg.sv
// One combinational carry-select slice of the dpa_pipe adder.
// Ports:
//   a, b      in  SEG  operand bits of this segment (b already inverted for subtract)
//   ci        in  1    segment carry-in
//   sum       out SEG  segment sum bits
//   co        out 1    carry out of the segment MSB
//   c_msb_in  out 1    carry into the segment MSB (used for overflow detection)
module dpa_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Both candidate sums (p for carry 0, ~p for carry 1) exist per bit;
  // the rippled carry picks one.
  always_comb begin
    c    = '0;
    c[0] = ci;
    sum  = '0;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      sum[i] = c[i] ? ~p[i] : p[i];
    end
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/dpa_pipe.sv
// Pipelined carry-select adder/subtractor with signed absolute difference,
// arithmetic flags and valid/ready flow control. One register stage per
// carry segment plus a final flag/negate stage: latency STAGES+1 cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake (in_ready = ~out_valid | out_ready)
//   a, b, cin, alu_op         operands, carry-in (ADD only), operation
//   out_valid / out_ready     output handshake
//   result                    sum / difference / magnitude
//   cout, negative_flag,
//   overflow_flag, zero_flag  status flags
//   op_err                    unsupported opcode
module dpa_pipe
  import dpa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int OP_LEN = dpa_pkg::OP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic [OP_LEN-1:0] alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic              negative_flag,
  output logic              overflow_flag,
  output logic              zero_flag,
  output logic              op_err
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $fatal(1, "dpa_pipe: WIDTH must be a multiple of STAGES");
  end
  // Operands are forwarded through STAGES-1 registers, so at least two stages.
  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "dpa_pipe: STAGES must be at least 2");
  end

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1'b1);
  endfunction

  logic en;
  logic out_valid_q;

  // Whole pipe advances together; the only combinational path is out_ready -> in_ready.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Operand conditioning: subtract and absdiff are a + ~b + 1.
  logic [WIDTH-1:0] b_eff;
  logic             ci0;

  always_comb begin
    b_eff = b;
    ci0   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        b_eff = b;
        ci0   = cin;
      end
      OP_SUB, OP_ABSDIFF: begin
        b_eff = ~b;
        ci0   = 1'b1;
      end
      default: begin
        b_eff = b;
        ci0   = 1'b0;
      end
    endcase
  end

  logic              vld_q  [STAGES];
  logic [OP_LEN-1:0] op_q   [STAGES];
  logic [WIDTH-1:0]  sum_q  [STAGES];
  logic              cy_q   [STAGES];
  // Not-yet-consumed operand bits, shifted so the next segment sits at bit 0.
  logic [WIDTH-1:0]  opa_q  [STAGES-1];
  logic [WIDTH-1:0]  opb_q  [STAGES-1];
  logic              cmsb_q;

  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0] seg_cmsb;
  logic              unused_cmsb;

  // Only the top segment's MSB carry-in feeds the overflow flag.
  assign unused_cmsb = ^seg_cmsb[STAGES-2:0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic           seg_ci;

    dpa_seg #(.SEG(SEG)) u_seg (
      .a        (seg_a),
      .b        (seg_b),
      .ci       (seg_ci),
      .sum      (seg_sum[k]),
      .co       (seg_co[k]),
      .c_msb_in (seg_cmsb[k])
    );

    if (k == 0) begin : g_first
      assign seg_a  = a[SEG-1:0];
      assign seg_b  = b_eff[SEG-1:0];
      assign seg_ci = ci0;

      // ---- stage 0 boundary: segment 0 from the input ports ----
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q[0] <= 1'b0;
        end else if (en) begin
          vld_q[0] <= in_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          op_q[0]  <= alu_op;
          cy_q[0]  <= seg_co[0];
          sum_q[0] <= {{(WIDTH-SEG){1'b0}}, seg_sum[0]};
          opa_q[0] <= a >> SEG;
          opb_q[0] <= b_eff >> SEG;
        end
      end
    end else begin : g_next
      assign seg_a  = opa_q[k-1][SEG-1:0];
      assign seg_b  = opb_q[k-1][SEG-1:0];
      assign seg_ci = cy_q[k-1];

      // ---- stage k boundary: segment k from the previous stage ----
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q[k] <= 1'b0;
        end else if (en) begin
          vld_q[k] <= vld_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (en) begin
          op_q[k]                  <= op_q[k-1];
          cy_q[k]                  <= seg_co[k];
          sum_q[k]                 <= sum_q[k-1];
          sum_q[k][k*SEG +: SEG]   <= seg_sum[k];
        end
      end

      if (k < LAST) begin : g_fwd
        always_ff @(posedge clk) begin
          if (en) begin
            opa_q[k] <= opa_q[k-1] >> SEG;
            opb_q[k] <= opb_q[k-1] >> SEG;
          end
        end
      end else begin : g_top
        always_ff @(posedge clk) begin
          if (en) begin
            cmsb_q <= seg_cmsb[k];
          end
        end
      end
    end
  end

  // Final stage: flags and conditional negate for absdiff.
  logic [WIDTH-1:0] d;
  logic             v;
  logic             s;
  logic [WIDTH-1:0] result_d;
  dpa_flags_t       flags_d;

  always_comb begin
    d        = sum_q[LAST];
    v        = cy_q[LAST] ^ cmsb_q;
    // True sign of a-b, valid even when the raw difference overflowed.
    s        = d[WIDTH-1] ^ v;
    result_d = '0;
    flags_d  = '0;
    case (op_q[LAST])
      OP_ADD, OP_SUB: begin
        result_d         = d;
        flags_d.cout     = cy_q[LAST];
        flags_d.negative = d[WIDTH-1];
        flags_d.overflow = v;
        flags_d.zero     = (d == '0);
      end
      OP_ABSDIFF: begin
        // Magnitude is read as unsigned, so -(-2^(W-1)) is exact.
        result_d     = s ? negate(d) : d;
        flags_d.cout = s;
        flags_d.zero = (result_d == '0);
      end
      default: begin
        flags_d.op_err = 1'b1;
      end
    endcase
  end

  logic [WIDTH-1:0] result_q;
  dpa_flags_t       flags_q;

  // ---- output stage boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= vld_q[LAST];
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign cout          = flags_q.cout;
  assign negative_flag = flags_q.negative;
  assign overflow_flag = flags_q.overflow;
  assign zero_flag     = flags_q.zero;
  assign op_err        = flags_q.op_err;

endmodule

// File: tb/tb_dpa_pipe.sv
// Self-checking bench for dpa_pipe (WIDTH=32, STAGES=4): directed vector
// table, output stall hold, reset with ops in flight, and a random stream
// under toggling out_ready checked against a reference model.
module tb_dpa_pipe;
  import dpa_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic [4:0]    alu_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          negative_flag;
  logic          overflow_flag;
  logic          zero_flag;
  logic          op_err;

  always #5 clk = ~clk;

  dpa_pipe #(.WIDTH(W), .STAGES(4), .OP_LEN(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .alu_op        (alu_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .cout          (cout),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag),
    .op_err        (op_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // flg = {cout, negative, overflow, zero, op_err}
  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic [4:0]   flg;
    logic         chk_zero;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] act_flags();
    return {cout, negative_flag, overflow_flag, zero_flag, op_err};
  endfunction

  function automatic vec_t mkv(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic [W-1:0] r, input logic [4:0] f,
                               input logic cz);
    vec_t t;
    t.op = op; t.a = x; t.b = y; t.cin = ci; t.res = r; t.flg = f; t.chk_zero = cz;
    return t;
  endfunction

  // Reference model built on wide integer arithmetic and signed compare.
  function automatic vec_t ref_model(input logic [4:0] op, input logic [W-1:0] x,
                                     input logic [W-1:0] y, input logic ci);
    vec_t        t;
    logic [W:0]  full;
    logic        c, n, o, e;
    t = mkv(op, x, y, ci, '0, '0, 1'b1);
    c = 1'b0; n = 1'b0; o = 1'b0; e = 1'b0;
    case (op)
      OP_ADD: begin
        full  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        t.res = full[W-1:0];
        c     = full[W];
        n     = t.res[W-1];
        o     = (x[W-1] == y[W-1]) && (t.res[W-1] != x[W-1]);
      end
      OP_SUB: begin
        full  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        t.res = full[W-1:0];
        c     = full[W];
        n     = t.res[W-1];
        o     = (x[W-1] != y[W-1]) && (t.res[W-1] != x[W-1]);
      end
      OP_ABSDIFF: begin
        if ($signed(x) < $signed(y)) begin
          t.res = y - x;
          c     = 1'b1;
        end else begin
          t.res = x - y;
        end
      end
      default: begin
        e          = 1'b1;
        t.chk_zero = 1'b0;
      end
    endcase
    t.flg = {c, n, o, (e == 1'b0) && (t.res == '0), e};
    return t;
  endfunction

  task automatic drive(input vec_t v);
    alu_op = v.op; a = v.a; b = v.b; cin = v.cin;
  endtask

  task automatic cmp_out(input string name, input vec_t v);
    logic [4:0] m;
    m = v.chk_zero ? 5'b11111 : 5'b11101;
    check({name, " result"}, 64'(result), 64'(v.res));
    check({name, " flags"}, 64'(act_flags() & m), 64'(v.flg & m));
  endtask

  // Single op with out_ready high; checks latency and outputs.
  task automatic run_vec(input vec_t v, input string name);
    int cnt;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v);
    in_valid = 1'b1;
    #1 check({name, " in_ready"}, 64'(in_ready), 64'(1));
    cnt = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
    end while (!out_valid && cnt < 20);
    check({name, " latency"}, 64'(cnt), 64'(5));
    cmp_out(name, v);
  endtask

  task automatic wait_out_valid(input string name);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " out_valid reached"}, 64'(out_valid), 64'(1));
  endtask

  task automatic run_stall();
    vec_t v;
    logic [W-1:0] hres;
    logic [4:0]   hflg;
    v = mkv(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 5'b00000, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("stall");
    cmp_out("stall first", v);
    #1 check("stall in_ready low", 64'(in_ready), 64'(0));
    hres = result;
    hflg = act_flags();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stall hold %0d", i), {31'b0, out_valid, result}, {31'b0, 1'b1, hres});
      check($sformatf("stall flags %0d", i), 64'(act_flags()), 64'(hflg));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall released", 64'(out_valid), 64'(0));
  endtask

  task automatic run_reset_inflight();
    vec_t v0, v1, v2;
    int   seen;
    v0 = mkv(OP_ADD, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0001, 5'b01000, 1'b1);
    v1 = mkv(OP_SUB, 32'd9, 32'd4, 1'b0, 32'd5, 5'b10000, 1'b1);
    v2 = mkv(OP_ABSDIFF, 32'd1, 32'd2, 1'b0, 32'd1, 5'b10000, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(v0); in_valid = 1'b1;
    @(negedge clk);
    drive(v1);
    @(negedge clk);
    drive(v2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("rst inflight");
    cmp_out("rst inflight head", v0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst result", 64'(result), 64'(0));
    check("rst flags", 64'(act_flags()), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst discarded ops", 64'(seen), 64'(0));
    run_vec(mkv(OP_SUB, 32'd100, 32'd58, 1'b0, 32'd42, 5'b10000, 1'b1), "post-rst");
  endtask

  task automatic run_stream();
    vec_t         q[$];
    vec_t         cur;
    vec_t         exp;
    int           issued, got, cyc, sel;
    logic         held, need, fire_in, fire_out;
    logic [W-1:0] hres;
    logic [4:0]   hflg;
    issued = 0; got = 0; cyc = 0;
    held = 1'b0; need = 1'b1; hres = '0; hflg = '0;
    cur = mkv(OP_ADD, '0, '0, 1'b0, '0, '0, 1'b1);
    while ((issued < 16 || got < 16) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (need) begin
        if (issued < 16) begin
          sel = $urandom_range(0, 2);
          cur = ref_model((sel == 0) ? OP_ADD : (sel == 1) ? OP_SUB : OP_ABSDIFF,
                          $urandom, ((issued % 4) == 3) ? 32'h8000_0000 : $urandom,
                          1'($urandom_range(0, 1)));
          drive(cur);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (held) begin
        check("stream hold", {31'b0, out_valid, result}, {31'b0, 1'b1, hres});
        check("stream hold flags", 64'(act_flags()), 64'(hflg));
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          check("stream extra output", 64'(1), 64'(0));
        end else begin
          exp = q.pop_front();
          cmp_out($sformatf("stream %0d", got), exp);
        end
        got++;
      end
      held = out_valid & ~out_ready;
      hres = result;
      hflg = act_flags();
      if (fire_in) begin
        q.push_back(cur);
        issued++;
      end
      need = fire_in | ~in_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream outputs received", 64'(got), 64'(16));
    check("stream queue drained", 64'(q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; alu_op = OP_ADD;

    vecs[0]  = mkv(OP_ADD,     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 5'b01100, 1'b1);
    vecs[1]  = mkv(OP_SUB,     32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 5'b10010, 1'b1);
    vecs[2]  = mkv(OP_SUB,     32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 5'b01000, 1'b1);
    vecs[3]  = mkv(OP_ABSDIFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'b10000, 1'b1);
    vecs[4]  = mkv(OP_ABSDIFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 5'b00000, 1'b1);
    vecs[5]  = mkv(OP_ADD,     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 5'b10010, 1'b1);
    vecs[6]  = mkv(OP_ADD,     32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 5'b00000, 1'b1);
    vecs[7]  = mkv(OP_ABSDIFF, 32'h0000_0003, 32'h0000_000A, 1'b0, 32'h0000_0007, 5'b10000, 1'b1);
    vecs[8]  = mkv(OP_ABSDIFF, 32'h0000_000A, 32'h0000_000A, 1'b0, 32'h0000_0000, 5'b00010, 1'b1);
    vecs[9]  = mkv(5'b11111,   32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0000_0000, 5'b00001, 1'b0);
    vecs[10] = mkv(5'b00000,   32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'h0000_0000, 5'b00001, 1'b0);
    vecs[11] = mkv(OP_SUB,     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 5'b10100, 1'b1);
    vecs[12] = mkv(OP_ABSDIFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, 5'b10000, 1'b1);

    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset flags", 64'(act_flags()), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    run_stall();
    run_reset_inflight();
    run_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
